// File: rtl/tpu_mem_pkg.sv
// Shared definitions for the RAM row stream reader: FSM state type and row FIFO depth.
package tpu_mem_pkg;

  localparam int unsigned FifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO with registered occupancy count; head is visible combinationally.
module row_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem_q[rd_ptr_q];
  assign count  = count_q;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a run of RAM rows out through a ready/valid port, throttled by a small row FIFO
// so that backpressure never loses data returning from the registered-read RAM.
module ram_stream_reader
  import tpu_mem_pkg::*;
#(
  parameter int unsigned BIT_WIDTH     = 32,
  parameter int unsigned RAM_WIDTH     = 16,
  parameter int unsigned RAM_ADDR_BITS = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid_in,
  output logic                           cmd_ready_out,
  input  logic [RAM_ADDR_BITS-1:0]       cmd_addr_in,
  input  logic [RAM_ADDR_BITS:0]         cmd_len_in,
  output logic                           ram_we_out,
  output logic [RAM_ADDR_BITS-1:0]       ram_addr_out,
  output logic [RAM_WIDTH*BIT_WIDTH-1:0] ram_wdata_out,
  input  logic [RAM_WIDTH*BIT_WIDTH-1:0] ram_rdata_in,
  output logic                           data_valid_out,
  input  logic                           data_ready_in,
  output logic [RAM_WIDTH*BIT_WIDTH-1:0] data_out,
  output logic                           data_last_out,
  output logic                           done_out
);

  localparam int unsigned RowW = RAM_WIDTH * BIT_WIDTH;
  localparam int unsigned LenW = RAM_ADDR_BITS + 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  rd_state_e              state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [LenW-1:0]        rem_q, rem_d;
  logic                   inflight_q, inflight_last_q;
  logic                   done_q, done_d;
  logic                   issue;
  logic                   fifo_pop, fifo_empty;
  logic [CntW-1:0]        fifo_count;
  logic [RowW:0]          fifo_head;

  // Top bit of each FIFO entry tags the final row of the command.
  row_fifo #(
    .WIDTH(RowW + 1),
    .DEPTH(FifoDepth)
  ) u_row_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (fifo_pop),
    .wdata({inflight_last_q, ram_rdata_in}),
    .rdata(fifo_head),
    .count(fifo_count),
    .empty(fifo_empty)
  );

  assign cmd_ready_out  = (state_q == StIdle);
  assign ram_we_out     = 1'b0;
  assign ram_wdata_out  = '0;
  assign ram_addr_out   = addr_q;
  assign data_valid_out = !fifo_empty;
  assign data_out       = fifo_head[RowW-1:0];
  assign data_last_out  = data_valid_out && fifo_head[RowW];
  assign done_out       = done_q;
  assign fifo_pop       = data_valid_out && data_ready_in;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_in) begin
          if (cmd_len_in != '0) begin
            addr_d  = cmd_addr_in;
            rem_d   = cmd_len_in;
            state_d = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        // Credit check uses registered occupancy only; a same-cycle pop earns nothing.
        if ((32'(fifo_count) + 32'(inflight_q)) < FifoDepth) begin
          issue  = 1'b1;
          addr_d = addr_q + RAM_ADDR_BITS'(1);
          rem_d  = rem_q - LenW'(1);
          if (rem_q == LenW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fifo_pop && fifo_head[RowW]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LenW'(1));
      done_q          <= done_d;
    end
  end

endmodule
